// File: rtl/nm_sparse_pkg.sv
// Shared types and helpers for the N:M structured-sparse MAC processing element.
// Imported by the mask decoder and the PE top.
package nm_sparse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } pe_state_e;

    localparam int POP_W = 64;

    // A one-position group still needs a 1-bit index field.
    function automatic int idx_bw(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    function automatic int lane_sum_bw(input int bw, input int lanes);
        return 2 * bw + $clog2(lanes);
    endfunction

    function automatic int popcount(input logic [POP_W-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < POP_W; i++) begin
            c += int'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/nm_mask_decoder.sv
// Combinational N:M mask decoder: k-th set bit of the mask becomes slot k.
// Surplus set bits are ignored; missing ones leave slots invalid.
module nm_mask_decoder
    import nm_sparse_pkg::*;
#(
    parameter  int M      = 4,
    parameter  int NNZ    = 2,
    localparam int IDX_BW = idx_bw(M)
) (
    input  logic [M-1:0]                 mask_i,
    output logic [NNZ-1:0][IDX_BW-1:0]   slot_idx_o,
    output logic [NNZ-1:0]               slot_valid_o,
    output logic                         mask_err_o
);

    always_comb begin : decode
        int cnt;
        slot_idx_o   = '0;
        slot_valid_o = '0;
        cnt          = 0;
        for (int b = 0; b < M; b++) begin
            if (mask_i[b]) begin
                for (int k = 0; k < NNZ; k++) begin
                    if (cnt == k) begin
                        slot_idx_o[k]   = IDX_BW'(b);
                        slot_valid_o[k] = 1'b1;
                    end
                end
                cnt++;
            end
        end
    end

    assign mask_err_o = (popcount(POP_W'(mask_i)) != NNZ);

endmodule

// File: rtl/nm_sparse_mac_pe.sv
// N:M structured-sparse MAC processing element with two-stage accumulate
// pipeline, valid/ready result port and a clock-enable request for its gate.
module nm_sparse_mac_pe
    import nm_sparse_pkg::*;
#(
    parameter  int BW      = 4,
    parameter  int PSUM_BW = 20,
    parameter  int NNZ     = 2,
    parameter  int M       = 4,
    parameter  int LANES   = 2,
    parameter  int SAT     = 0,
    localparam int IDX_BW  = idx_bw(M)
) (
    input  logic                    gated_clk,
    input  logic                    reset,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [NNZ*BW-1:0]       cfg_weights,
    input  logic [M-1:0]            cfg_mask,
    input  logic [PSUM_BW-1:0]      psum_in,
    input  logic                    act_valid,
    output logic                    act_ready,
    input  logic [LANES*BW-1:0]     act_data,
    input  logic [LANES*IDX_BW-1:0] act_idx,
    input  logic                    act_last,
    output logic [PSUM_BW-1:0]      psum_out,
    output logic                    psum_out_valid,
    input  logic                    psum_out_ready,
    output logic                    mask_err,
    output logic                    clk_en_req
);

    localparam int SUM_BW = lane_sum_bw(BW, LANES);

    pe_state_e state_q, state_d;

    logic [NNZ-1:0][BW-1:0]     w_q;
    logic [NNZ-1:0][IDX_BW-1:0] sidx_q;
    logic [NNZ-1:0][IDX_BW-1:0] dec_idx;
    logic [NNZ-1:0]             svld_q;
    logic [NNZ-1:0]             dec_vld;
    logic                       dec_err;
    logic                       mask_err_q;

    logic [PSUM_BW-1:0] acc_q, acc_d;
    logic [PSUM_BW-1:0] psum_out_q;
    logic [PSUM_BW:0]   acc_sum;
    logic               s1_valid_q;
    logic [SUM_BW-1:0]  s1_sum_q;
    logic [SUM_BW-1:0]  lane_sum;

    logic cfg_fire;
    logic act_fire;

    nm_mask_decoder #(
        .M   (M),
        .NNZ (NNZ)
    ) u_dec (
        .mask_i       (cfg_mask),
        .slot_idx_o   (dec_idx),
        .slot_valid_o (dec_vld),
        .mask_err_o   (dec_err)
    );

    assign cfg_ready = (state_q == ST_IDLE);
    assign act_ready = (state_q == ST_RUN);
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign act_fire  = act_valid && act_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (cfg_valid)      state_d = ST_RUN;
            ST_RUN:   if (act_fire && act_last) state_d = ST_DRAIN;
            // Leave only once the last stage-1 sum has reached the accumulator.
            ST_DRAIN: if (!s1_valid_q)    state_d = ST_OUT;
            ST_OUT:   if (psum_out_ready) state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    // Stage 1: index-matched lane products, duplicates both count.
    always_comb begin : lanes
        logic [2*BW-1:0] prod;
        lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            prod = '0;
            for (int k = 0; k < NNZ; k++) begin
                if (svld_q[k] && (sidx_q[k] == act_idx[l*IDX_BW +: IDX_BW])) begin
                    prod = (2*BW)'(w_q[k]) * (2*BW)'(act_data[l*BW +: BW]);
                end
            end
            lane_sum = lane_sum + SUM_BW'(prod);
        end
    end

    // Stage 2: accumulate with optional saturation at all-ones.
    always_comb begin
        acc_sum = {1'b0, acc_q} + (PSUM_BW+1)'(s1_sum_q);
        acc_d   = acc_q;
        if (s1_valid_q) begin
            if ((SAT != 0) && acc_sum[PSUM_BW]) begin
                acc_d = '1;
            end else begin
                acc_d = acc_sum[PSUM_BW-1:0];
            end
        end
    end

    always_ff @(posedge gated_clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            psum_out_q <= '0;
            mask_err_q <= 1'b0;
            w_q        <= '0;
            sidx_q     <= '0;
            svld_q     <= '0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= act_fire;
            if (act_fire) begin
                s1_sum_q <= lane_sum;
            end
            if (cfg_fire) begin
                acc_q      <= psum_in;
                w_q        <= cfg_weights;
                sidx_q     <= dec_idx;
                svld_q     <= dec_vld;
                mask_err_q <= dec_err;
            end else begin
                acc_q <= acc_d;
            end
            if ((state_q == ST_DRAIN) && (state_d == ST_OUT)) begin
                psum_out_q <= acc_q;
            end
        end
    end

    assign psum_out       = psum_out_q;
    assign psum_out_valid = (state_q == ST_OUT);
    assign mask_err       = mask_err_q;

    assign clk_en_req = reset
                      | ((state_q == ST_IDLE) & cfg_valid)
                      | ((state_q == ST_RUN) & act_valid)
                      | s1_valid_q
                      | (state_q == ST_DRAIN)
                      | (state_q == ST_OUT);

endmodule

// File: tb/tb_nm_sparse_mac_pe.sv
// Directed plus randomized bench for nm_sparse_mac_pe, wrap and saturating
// variants driven in parallel against a rank-based reference model.
module tb_nm_sparse_mac_pe;

    localparam int     BW      = 4;
    localparam int     PSUM_BW = 20;
    localparam int     NNZ     = 2;
    localparam int     M       = 4;
    localparam int     LANES   = 2;
    localparam longint PMAX    = (longint'(1) << PSUM_BW) - 1;

    logic                 gated_clk = 1'b0;
    logic                 reset;
    logic                 cfg_valid;
    logic [NNZ*BW-1:0]    cfg_weights;
    logic [M-1:0]         cfg_mask;
    logic [PSUM_BW-1:0]   psum_in;
    logic                 act_valid;
    logic [LANES*BW-1:0]  act_data;
    logic [LANES*2-1:0]   act_idx;
    logic                 act_last;
    logic                 psum_out_ready;

    logic                 cfg_ready_w, act_ready_w, valid_w, err_w, cen_w;
    logic [PSUM_BW-1:0]   psum_w;
    logic                 cfg_ready_s, act_ready_s, valid_s, err_s, cen_s;
    logic [PSUM_BW-1:0]   psum_s;

    int checks   = 0;
    int failures = 0;
    int ba[16][2];
    int bi[16][2];

    always #5 gated_clk = ~gated_clk;

    nm_sparse_mac_pe #(.SAT(0)) u_wrap (
        .gated_clk      (gated_clk),
        .reset          (reset),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready_w),
        .cfg_weights    (cfg_weights),
        .cfg_mask       (cfg_mask),
        .psum_in        (psum_in),
        .act_valid      (act_valid),
        .act_ready      (act_ready_w),
        .act_data       (act_data),
        .act_idx        (act_idx),
        .act_last       (act_last),
        .psum_out       (psum_w),
        .psum_out_valid (valid_w),
        .psum_out_ready (psum_out_ready),
        .mask_err       (err_w),
        .clk_en_req     (cen_w)
    );

    nm_sparse_mac_pe #(.SAT(1)) u_sat (
        .gated_clk      (gated_clk),
        .reset          (reset),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready_s),
        .cfg_weights    (cfg_weights),
        .cfg_mask       (cfg_mask),
        .psum_in        (psum_in),
        .act_valid      (act_valid),
        .act_ready      (act_ready_s),
        .act_data       (act_data),
        .act_idx        (act_idx),
        .act_last       (act_last),
        .psum_out       (psum_s),
        .psum_out_valid (valid_s),
        .psum_out_ready (psum_out_ready),
        .mask_err       (err_s),
        .clk_en_req     (cen_s)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge gated_clk);
        #1;
    endtask

    // Slot that owns position pos: its rank among set bits, if within NNZ.
    function automatic int slot_of(input logic [3:0] mask, input int pos);
        int rank;
        rank = 0;
        if (!mask[pos]) return -1;
        for (int b = 0; b < pos; b++) begin
            if (mask[b]) rank++;
        end
        return (rank < NNZ) ? rank : -1;
    endfunction

    task automatic run_job(input logic [3:0] mask, input logic [3:0] w0,
                           input logic [3:0] w1, input logic [19:0] seed,
                           input int nb, input int maxgap, input int hold);
        longint accw, accs, s;
        int     sl, g, wk;
        accw = longint'(seed);
        accs = longint'(seed);
        chk("cfg_ready_idle", cfg_ready_w, 1);
        cfg_valid   = 1'b1;
        cfg_mask    = mask;
        cfg_weights = {w1, w0};
        psum_in     = seed;
        #1;
        chk("clk_en_cfg", cen_w, 1);
        tick();
        cfg_valid = 1'b0;
        chk("mask_err_w", err_w, ($countones(mask) != NNZ));
        chk("mask_err_s", err_s, ($countones(mask) != NNZ));
        for (int i = 0; i < nb; i++) begin
            g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            for (int j = 0; j < g; j++) begin
                act_valid = 1'b0;
                tick();
                chk("clk_en_gap", cen_w, 0);
                chk("act_ready_gap", act_ready_w, 1);
            end
            act_valid     = 1'b1;
            act_data[3:0] = 4'(ba[i][0]);
            act_data[7:4] = 4'(ba[i][1]);
            act_idx[1:0]  = 2'(bi[i][0]);
            act_idx[3:2]  = 2'(bi[i][1]);
            act_last      = (i == nb - 1);
            #1;
            chk("clk_en_beat", cen_w, 1);
            chk("act_ready_run", act_ready_w, 1);
            s = 0;
            for (int l = 0; l < LANES; l++) begin
                sl = slot_of(mask, bi[i][l]);
                if (sl >= 0) begin
                    wk = (sl == 0) ? int'(w0) : int'(w1);
                    s += longint'(wk * ba[i][l]);
                end
            end
            accw = (accw + s) % (PMAX + 1);
            accs = (accs + s > PMAX) ? PMAX : accs + s;
            tick();
        end
        act_valid = 1'b0;
        act_last  = 1'b0;
        chk("valid_t0", valid_w, 0);
        chk("act_ready_drain", act_ready_w, 0);
        tick();
        chk("valid_t1", valid_w, 0);
        tick();
        chk("valid_t2", valid_w, 1);
        chk("valid_t2_sat", valid_s, 1);
        chk("psum_wrap", psum_w, accw);
        chk("psum_sat", psum_s, accs);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_valid", valid_w, 1);
            chk("hold_psum", psum_w, accw);
            chk("hold_cfg_ready", cfg_ready_w, 0);
            chk("hold_act_ready", act_ready_w, 0);
            chk("hold_clk_en", cen_w, 1);
        end
        psum_out_ready = 1'b1;
        tick();
        psum_out_ready = 1'b0;
        chk("post_valid", valid_w, 0);
        chk("post_cfg_ready", cfg_ready_w, 1);
        chk("post_psum_kept", psum_w, accw);
        chk("post_clk_en", cen_w, 0);
    endtask

    initial begin
        reset          = 1'b1;
        cfg_valid      = 1'b0;
        cfg_weights    = '0;
        cfg_mask       = '0;
        psum_in        = '0;
        act_valid      = 1'b0;
        act_data       = '0;
        act_idx        = '0;
        act_last       = 1'b0;
        psum_out_ready = 1'b0;
        tick();
        tick();
        chk("rst_psum", psum_w, 0);
        chk("rst_valid", valid_w, 0);
        chk("rst_mask_err", err_w, 0);
        chk("rst_cfg_ready", cfg_ready_w, 1);
        chk("rst_act_ready", act_ready_w, 0);
        chk("rst_clk_en", cen_w, 1);
        reset = 1'b0;
        #1;
        chk("idle_clk_en", cen_w, 0);

        // Basic job, expected 126, with a 5-cycle stalled consumer.
        ba[0][0] = 2; bi[0][0] = 1; ba[0][1] = 4; bi[0][1] = 3;
        run_job(4'b1010, 4'd3, 4'd5, 20'd100, 1, 0, 5);

        // Non-matching beats with idle gaps: seed passes through.
        for (int i = 0; i < 4; i++) begin
            ba[i][0] = 9; bi[i][0] = 0; ba[i][1] = 11; bi[i][1] = 2;
        end
        run_job(4'b1010, 4'd3, 4'd5, 20'd100, 4, 3, 0);

        // Three set bits: mask_err, slots at idx0/idx1.
        ba[0][0] = 3; bi[0][0] = 2; ba[0][1] = 1; bi[0][1] = 0;
        run_job(4'b0111, 4'd2, 4'd7, 20'd0, 1, 0, 1);

        // One set bit, duplicate index on both lanes.
        ba[0][0] = 6; bi[0][0] = 2; ba[0][1] = 7; bi[0][1] = 2;
        run_job(4'b0100, 4'd9, 4'd4, 20'd1, 1, 0, 0);

        // Overflow: saturating instance clamps, wrapping one yields 440.
        ba[0][0] = 15; bi[0][0] = 1; ba[0][1] = 15; bi[0][1] = 3;
        run_job(4'b1010, 4'd15, 4'd15, 20'(PMAX - 9), 1, 0, 0);

        // Reset after the first of three beats discards the job.
        chk("pre_rst_cfg_ready", cfg_ready_w, 1);
        cfg_valid   = 1'b1;
        cfg_mask    = 4'b1010;
        cfg_weights = {4'd5, 4'd3};
        psum_in     = 20'd77;
        tick();
        cfg_valid = 1'b0;
        act_valid = 1'b1;
        act_data  = {4'd4, 4'd2};
        act_idx   = {2'd3, 2'd1};
        act_last  = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("rst_mid_clk_en", cen_w, 1);
        tick();
        reset     = 1'b0;
        act_valid = 1'b0;
        #1;
        chk("rst_mid_valid", valid_w, 0);
        chk("rst_mid_cfg_ready", cfg_ready_w, 1);
        chk("rst_mid_act_ready", act_ready_w, 0);
        chk("rst_mid_psum", psum_w, 0);
        chk("rst_mid_clk_en_low", cen_w, 0);
        ba[0][0] = 2; bi[0][0] = 1; ba[0][1] = 4; bi[0][1] = 3;
        run_job(4'b1010, 4'd3, 4'd5, 20'd0, 1, 0, 0);

        // Randomized jobs, seeds often near the top to exercise saturation.
        for (int j = 0; j < 25; j++) begin
            logic [3:0]  rm, rw0, rw1;
            logic [19:0] rs;
            int          nb;
            rm  = 4'($urandom_range(15, 0));
            rw0 = 4'($urandom_range(15, 0));
            rw1 = 4'($urandom_range(15, 0));
            if ($urandom_range(1, 0) == 1) begin
                rs = 20'(PMAX - longint'($urandom_range(600, 0)));
            end else begin
                rs = 20'($urandom);
            end
            nb = int'($urandom_range(6, 1));
            for (int i = 0; i < nb; i++) begin
                for (int l = 0; l < LANES; l++) begin
                    ba[i][l] = int'($urandom_range(15, 0));
                    bi[i][l] = int'($urandom_range(3, 0));
                end
            end
            run_job(rm, rw0, rw1, rs, nb, 2, int'($urandom_range(2, 0)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
